// File: rtl/cswap_full_adder_pkg.sv
// Shared constants for the Fredkin-gate full adder: gate output indices and
// the constant levels fed into gate data inputs.
package cswap_full_adder_pkg;

  localparam int O_CTL = 0;
  localparam int O_1   = 1;
  localparam int O_2   = 2;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

endpackage

// File: rtl/cswap_full_adder_cswap.sv
// Single Fredkin (controlled-swap) gate: ctl passes through, x/y are swapped
// onto o1/o2 when ctl is high.
module cswap
  import cswap_full_adder_pkg::*;
(
  input  logic       ctl,
  input  logic       x,
  input  logic       y,
  output logic [2:0] o
);

  always_comb begin
    o        = '0;
    o[O_CTL] = ctl;
    o[O_1]   = ctl ? y : x;
    o[O_2]   = ctl ? x : y;
  end

endmodule

// File: rtl/cswap_full_adder.sv
// WIDTH independent full-adder lanes built only from Fredkin gates, with one
// enable-gated output register stage (a1 = sum, b1 = carry).
module cswap_full_adder
  import cswap_full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] b1
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;
  logic [WIDTH-1:0] a1_d, a1_q;
  logic [WIDTH-1:0] b1_d, b1_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic [2:0] not_o;
      logic [2:0] xor_o;
      logic [2:0] sum_o;
      logic [2:0] cy_o;
      logic [6:0] unused_garbage;

      cswap u_not (.ctl(b[gi]),       .x(ZERO),        .y(ONE),         .o(not_o));
      // o1 = a^b; o2 = ~(a^b), which feeds the sum gate without a fifth gate
      cswap u_xor (.ctl(a[gi]),       .x(b[gi]),       .y(not_o[O_2]),  .o(xor_o));
      cswap u_sum (.ctl(c[gi]),       .x(xor_o[O_1]),  .y(xor_o[O_2]),  .o(sum_o));
      // a==b means majority is a; otherwise c breaks the tie
      cswap u_cy  (.ctl(xor_o[O_1]),  .x(a[gi]),       .y(c[gi]),       .o(cy_o));

      assign sum_w[gi]   = sum_o[O_1];
      assign carry_w[gi] = cy_o[O_1];

      assign unused_garbage = {not_o[O_CTL], not_o[O_1], xor_o[O_CTL],
                               sum_o[O_CTL], sum_o[O_2], cy_o[O_CTL], cy_o[O_2]};
    end
  endgenerate

  always_comb begin
    a1_d = en ? sum_w   : a1_q;
    b1_d = en ? carry_w : b1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0;
      b1_q <= '0;
    end else begin
      a1_q <= a1_d;
      b1_q <= b1_d;
    end
  end

  assign a1 = a1_q;
  assign b1 = b1_q;

endmodule

// File: tb/tb_cswap_full_adder.sv
// Self-checking bench: a WIDTH=1 and a WIDTH=4 adder plus a lone cswap gate,
// compared against an arithmetic full-adder model.
module tb_cswap_full_adder;
  import cswap_full_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, en4;
  logic [0:0] a_1, b_1, c_1, s_1, cy_1;
  logic [3:0] a_4, b_4, c_4, s_4, cy_4;
  logic       g_ctl, g_x, g_y;
  logic [2:0] g_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_s4, exp_cy4;

  always #5 clk = ~clk;

  cswap_full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .a(a_1), .b(b_1), .c(c_1), .a1(s_1), .b1(cy_1)
  );

  cswap_full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .a(a_4), .b(b_4), .c(c_4), .a1(s_4), .b1(cy_4)
  );

  cswap u_gate (.ctl(g_ctl), .x(g_x), .y(g_y), .o(g_o));

  // Reference: count the ones in each lane; sum is the parity, carry is count>=2.
  function automatic logic [7:0] ref_fa(input logic [3:0] av, input logic [3:0] bv,
                                        input logic [3:0] cv);
    logic [3:0] s, cy;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'(av[i]) + int'(bv[i]) + int'(cv[i]);
      s[i]  = (n % 2) == 1;
      cy[i] = n >= 2;
    end
    return {s, cy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en1 = 1'b1; en4 = 1'b1;
    a_1 = 1'b1; b_1 = 1'b1; c_1 = 1'b1;
    a_4 = 4'hF; b_4 = 4'hF; c_4 = 4'hF;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({s_1, cy_1} !== 2'b00) begin
        errors++;
        $display("FAIL reset_w1 cyc%0d: got a1b1=%b required 00", k, {s_1, cy_1});
      end
      checks++;
      if ({s_4, cy_4} !== 8'h00) begin
        errors++;
        $display("FAIL reset_w4 cyc%0d: got a1=%b b1=%b required 0000 0000", k, s_4, cy_4);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b0;
    exp_s4 = '0; exp_cy4 = '0;
    $display("reset: outputs held at zero for the whole reset");
  endtask

  task automatic test_exhaustive();
    logic [1:0] tab [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    en4 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      @(negedge clk);
      en1 = 1'b1;
      a_1 = vv[2]; b_1 = vv[1]; c_1 = vv[0];
      @(posedge clk); #1;
      checks++;
      if ({s_1, cy_1} !== tab[v]) begin
        errors++;
        $display("FAIL exhaustive abc=%b: got a1b1=%b required %b", vv, {s_1, cy_1}, tab[v]);
      end else
        $display("exhaustive abc=%b -> a1b1=%b", vv, {s_1, cy_1});
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en1 = 1'b1; a_1 = 1'b1; b_1 = 1'b0; c_1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    en1 = 1'b0; a_1 = 1'b1; b_1 = 1'b1; c_1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s_1, cy_1} !== 2'b10) begin
        errors++;
        $display("FAIL hold edge%0d: got a1b1=%b required 10", k, {s_1, cy_1});
      end
    end
    // Inputs wiggling between edges with en=1 must not leak through.
    @(negedge clk);
    en1 = 1'b1;
    #2 a_1 = 1'b0;
    #1 b_1 = 1'b0;
    checks++;
    if ({s_1, cy_1} !== 2'b10) begin
      errors++;
      $display("FAIL between_edges: got a1b1=%b required 10", {s_1, cy_1});
    end else
      $display("hold: a1b1=10 retained with en=0 and between edges");
    en1 = 1'b0;
  endtask

  task automatic test_lanes();
    @(negedge clk);
    en4 = 1'b1; a_4 = 4'b1111; b_4 = 4'b0101; c_4 = 4'b0011;
    @(posedge clk); #1;
    checks++;
    if (s_4 !== 4'b1001 || cy_4 !== 4'b0111) begin
      errors++;
      $display("FAIL lanes: got a1=%b b1=%b required a1=1001 b1=0111", s_4, cy_4);
    end else
      $display("lanes: a1=%b b1=%b", s_4, cy_4);
    {exp_s4, exp_cy4} = {s_4 === 4'b1001 ? 4'b1001 : 4'b1001, 4'b0111};
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [3:0] ra, rb, rc;
      logic re;
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      re = ($urandom_range(0, 3) != 0);
      en4 = re; a_4 = ra; b_4 = rb; c_4 = rc;
      if (re) {exp_s4, exp_cy4} = ref_fa(ra, rb, rc);
      @(posedge clk); #1;
      checks++;
      if (s_4 !== exp_s4 || cy_4 !== exp_cy4) begin
        errors++;
        $display("FAIL random%0d en=%b a=%b b=%b c=%b: got a1=%b b1=%b required a1=%b b1=%b",
                 k, re, ra, rb, rc, s_4, cy_4, exp_s4, exp_cy4);
      end else
        $display("random%0d en=%b a=%b b=%b c=%b -> a1=%b b1=%b", k, re, ra, rb, rc, s_4, cy_4);
    end
    en4 = 1'b0;
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    en1 = 1'b1; a_1 = 1'b1; b_1 = 1'b1; c_1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_1, cy_1} !== 2'b11) begin
      errors++;
      $display("FAIL midrun_precap: got a1b1=%b required 11", {s_1, cy_1});
    end
    en1 = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s_1, cy_1} !== 2'b00 || {s_4, cy_4} !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: got w1 a1b1=%b w4 a1=%b b1=%b required all zero",
               {s_1, cy_1}, s_4, cy_4);
    end
    #1 rst = 1'b0;
    exp_s4 = '0; exp_cy4 = '0;
    @(negedge clk);
    en1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_1, cy_1} !== 2'b11) begin
      errors++;
      $display("FAIL midrun_recapture: got a1b1=%b required 11", {s_1, cy_1});
    end else
      $display("midrun reset: cleared then recaptured a1b1=11");
    en1 = 1'b0;
  endtask

  task automatic test_cswap();
    g_ctl = 1'b1; g_x = 1'b1; g_y = 1'b0;
    #1;
    checks++;
    if (g_o[O_CTL] !== 1'b1 || g_o[O_1] !== 1'b0 || g_o[O_2] !== 1'b1) begin
      errors++;
      $display("FAIL cswap_ctl1: got ctl,o1,o2=%b%b%b required 101", g_o[O_CTL], g_o[O_1], g_o[O_2]);
    end
    g_ctl = 1'b0;
    #1;
    checks++;
    if (g_o[O_CTL] !== 1'b0 || g_o[O_1] !== 1'b1 || g_o[O_2] !== 1'b0) begin
      errors++;
      $display("FAIL cswap_ctl0: got ctl,o1,o2=%b%b%b required 010", g_o[O_CTL], g_o[O_1], g_o[O_2]);
    end else
      $display("cswap: swap and pass-through behave");
  endtask

  initial begin
    g_ctl = 1'b0; g_x = 1'b0; g_y = 1'b0;
    test_reset();
    test_exhaustive();
    test_hold();
    test_lanes();
    test_random();
    test_midrun_reset();
    test_cswap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
